// File: rtl/mchan_fifo.sv
// mchan_fifo
//   NCH independent FIFOs of DEPTH entries, each with its own push port,
//   full/empty flags, synchronous flush and push-stall timeout detector.
//   A single shared pop port drains non-empty channels in round-robin order
//   and returns the popped word together with its channel tag.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   push_req   per-channel push request (NCH)
//   push_data  per-channel push data, channel c at [c*WIDTH +: WIDTH]
//   push_ack   per-channel push accept (combinational)
//   flush      per-channel synchronous clear
//   pop_req    consumer pop request
//   pop_ack    pop accept (combinational)
//   pop_ch     channel granted this cycle, 0 when nothing is eligible
//   data_out   popped data, registered
//   data_ch    channel tag of data_out, registered
//   full       per-channel count == DEPTH
//   empty      per-channel count == 0
//   timeout    per-channel push stalled for TMO cycles
module mchan_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int L2D   = 4,
  parameter int NCH   = 4,
  parameter int L2N   = 2,
  parameter int TMO   = 15
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NCH-1:0]       push_req,
  input  logic [NCH*WIDTH-1:0] push_data,
  output logic [NCH-1:0]       push_ack,
  input  logic [NCH-1:0]       flush,
  input  logic                 pop_req,
  output logic                 pop_ack,
  output logic [L2N-1:0]       pop_ch,
  output logic [WIDTH-1:0]     data_out,
  output logic [L2N-1:0]       data_ch,
  output logic [NCH-1:0]       full,
  output logic [NCH-1:0]       empty,
  output logic [NCH-1:0]       timeout
);

  logic [NCH-1:0][L2D-1:0] wptr_q, wptr_d;
  logic [NCH-1:0][L2D-1:0] rptr_q, rptr_d;
  logic [NCH-1:0][L2D-1:0] timer_q, timer_d;
  logic [NCH-1:0][L2D:0]   count_q, count_d;
  logic [L2N-1:0]          rr_ptr_q, rr_ptr_d;
  logic [L2N-1:0]          data_ch_q, data_ch_d;
  logic [WIDTH-1:0]        data_out_q, data_out_d;
  logic [WIDTH-1:0]        mem_q [NCH][DEPTH];

  logic [NCH-1:0] push_hsk;
  logic [NCH-1:0] eligible;
  logic           pop_hsk;
  logic           found;
  logic [L2N-1:0] grant;
  logic [L2N-1:0] idx;

  // Flags, push accept and timeout. Flags use start-of-cycle counts, so a
  // pop on a full channel cannot make room for a push in the same cycle.
  // Accepts are gated by resetn so nothing handshakes while reset is held.
  always_comb begin
    full     = '0;
    empty    = '0;
    push_ack = '0;
    eligible = '0;
    timeout  = '0;
    for (int c = 0; c < NCH; c++) begin
      full[c]     = (count_q[c] == (L2D+1)'(DEPTH));
      empty[c]    = (count_q[c] == '0);
      push_ack[c] = push_req[c] & ~full[c] & ~flush[c] & resetn;
      eligible[c] = ~empty[c] & ~flush[c];
      timeout[c]  = push_req[c] & ~push_ack[c] & (timer_q[c] == '0);
    end
    push_hsk = push_req & push_ack;
  end

  // Round-robin arbiter: first eligible channel scanning upward from rr_ptr.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = rr_ptr_q + L2N'(i);
      if (!found && eligible[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
    pop_ack = pop_req & found & resetn;
    pop_hsk = pop_ack;
    pop_ch  = grant;
  end

  // Next-state for pointers, counts, timers and the registered pop output.
  // Flush clears a channel's pointers and count but leaves its timer alone.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    timer_d    = timer_q;
    rr_ptr_d   = rr_ptr_q;
    data_out_d = data_out_q;
    data_ch_d  = data_ch_q;
    for (int c = 0; c < NCH; c++) begin
      if (flush[c]) begin
        wptr_d[c]  = '0;
        rptr_d[c]  = '0;
        count_d[c] = '0;
      end else begin
        if (push_hsk[c])
          wptr_d[c] = wptr_q[c] + L2D'(1);
        if (pop_hsk && grant == L2N'(c))
          rptr_d[c] = rptr_q[c] + L2D'(1);
        count_d[c] = count_q[c] + (L2D+1)'(push_hsk[c])
                     - (L2D+1)'(pop_hsk && grant == L2N'(c));
      end
      if (push_req[c] && !push_ack[c])
        timer_d[c] = (timer_q[c] != '0) ? timer_q[c] - L2D'(1) : '0;
      else
        timer_d[c] = L2D'(TMO);
    end
    if (pop_hsk) begin
      data_out_d = mem_q[grant][rptr_q[grant]];
      data_ch_d  = grant;
      rr_ptr_d   = grant + L2N'(1);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      timer_q    <= {NCH{L2D'(TMO)}};
      rr_ptr_q   <= '0;
      data_out_q <= '0;
      data_ch_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      rr_ptr_q   <= rr_ptr_d;
      data_out_q <= data_out_d;
      data_ch_q  <= data_ch_d;
    end
  end

  // Storage array; contents need no reset since counts gate every read.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push_hsk[c])
        mem_q[c][wptr_q[c]] <= push_data[c*WIDTH +: WIDTH];
    end
  end

  assign data_out = data_out_q;
  assign data_ch  = data_ch_q;

  // Producer and consumer obligations: hold a request until it is accepted.
  for (genvar c = 0; c < NCH; c++) begin : g_push_hold
    assume property (@(posedge clk) disable iff (!resetn)
      (push_req[c] && !push_ack[c]) |=>
        (push_req[c] && $stable(push_data[c*WIDTH +: WIDTH])));
  end

  assume property (@(posedge clk) disable iff (!resetn)
    (pop_req && !pop_ack) |=> pop_req);

endmodule

// File: tb/tb_mchan_fifo.sv
// tb_mchan_fifo
//   Directed self-checking bench for mchan_fifo: a vector table for the
//   single-channel fill/drain and hand-written sequences for round-robin,
//   push/pop on a full channel, timeout, flush and reset mid-stream.
module tb_mchan_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  push_req;
  logic [31:0] push_data;
  logic [3:0]  push_ack;
  logic [3:0]  flush;
  logic        pop_req;
  logic        pop_ack;
  logic [1:0]  pop_ch;
  logic [7:0]  data_out;
  logic [1:0]  data_ch;
  logic [3:0]  full;
  logic [3:0]  empty;
  logic [3:0]  timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  push_req;
    logic [31:0] push_data;
    logic        pop_req;
    logic [3:0]  flush;
    logic [3:0]  exp_push_ack;
    logic        exp_pop_ack;
    logic [1:0]  exp_pop_ch;
    logic [7:0]  exp_data_out;
    logic [1:0]  exp_data_ch;
    logic [3:0]  exp_full;
    logic [3:0]  exp_empty;
    logic [3:0]  exp_timeout;
  } vec_t;

  vec_t vecs[35];

  mchan_fifo #(
    .WIDTH(8), .DEPTH(16), .L2D(4), .NCH(4), .L2N(2), .TMO(15)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .push_req  (push_req),
    .push_data (push_data),
    .push_ack  (push_ack),
    .flush     (flush),
    .pop_req   (pop_req),
    .pop_ack   (pop_ack),
    .pop_ch    (pop_ch),
    .data_out  (data_out),
    .data_ch   (data_ch),
    .full      (full),
    .empty     (empty),
    .timeout   (timeout)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  // One cycle: drive inputs just after the rising edge, return at the
  // falling edge where outputs are sampled.
  task automatic applyStimulus(input logic [3:0] preq, input logic [31:0] pdata,
                               input logic popr, input logic [3:0] fl);
    @(posedge clk);
    #1;
    push_req  = preq;
    push_data = pdata;
    pop_req   = popr;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic resetDut();
    push_req  = '0;
    push_data = '0;
    pop_req   = 1'b0;
    flush     = '0;
    resetn    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [1:0] rr_ch [6];
    logic [7:0] rr_dat [6];

    // Fill/drain table for ch0: 16 pushes, a refused 17th held until a pop
    // makes room, then 17 pops draining 0x00..0x10.
    for (int k = 0; k < 35; k++) begin
      if (k <= 16)      cnt = k;
      else if (k <= 17) cnt = 16;
      else if (k == 18) cnt = 15;
      else              cnt = 34 - k;
      vecs[k].push_req     = (k <= 18) ? 4'b0001 : 4'b0000;
      vecs[k].push_data    = (k <= 15) ? 32'(k) : 32'h10;
      vecs[k].pop_req      = (k >= 17 && k <= 33);
      vecs[k].flush        = 4'b0000;
      vecs[k].exp_push_ack = (k <= 15 || k == 18) ? 4'b0001 : 4'b0000;
      vecs[k].exp_pop_ack  = (k >= 17 && k <= 33);
      vecs[k].exp_pop_ch   = 2'd0;
      vecs[k].exp_data_out = (k <= 18) ? 8'h00 : 8'(k - 18);
      vecs[k].exp_data_ch  = 2'd0;
      vecs[k].exp_full     = {3'b000, cnt == 16};
      vecs[k].exp_empty    = {3'b111, cnt == 0};
      vecs[k].exp_timeout  = 4'b0000;
    end
    rr_ch  = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    rr_dat = '{8'hA0, 8'hB0, 8'hD0, 8'hA1, 8'hB1, 8'hD1};

    // Reset values.
    resetDut();
    @(negedge clk);
    checkOutput("reset push_ack", 32'(push_ack), 32'h0);
    checkOutput("reset pop_ack",  32'(pop_ack),  32'h0);
    checkOutput("reset empty",    32'(empty),    32'hF);
    checkOutput("reset full",     32'(full),     32'h0);
    checkOutput("reset timeout",  32'(timeout),  32'h0);
    checkOutput("reset data_out", 32'(data_out), 32'h0);
    checkOutput("reset data_ch",  32'(data_ch),  32'h0);

    // Single-channel fill and drain.
    for (int k = 0; k < 35; k++) begin
      applyStimulus(vecs[k].push_req, vecs[k].push_data, vecs[k].pop_req, vecs[k].flush);
      checkOutput($sformatf("v%0d push_ack", k), 32'(push_ack), 32'(vecs[k].exp_push_ack));
      checkOutput($sformatf("v%0d pop_ack", k),  32'(pop_ack),  32'(vecs[k].exp_pop_ack));
      if (vecs[k].exp_pop_ack)
        checkOutput($sformatf("v%0d pop_ch", k), 32'(pop_ch), 32'(vecs[k].exp_pop_ch));
      checkOutput($sformatf("v%0d data_out", k), 32'(data_out), 32'(vecs[k].exp_data_out));
      checkOutput($sformatf("v%0d data_ch", k),  32'(data_ch),  32'(vecs[k].exp_data_ch));
      checkOutput($sformatf("v%0d full", k),     32'(full),     32'(vecs[k].exp_full));
      checkOutput($sformatf("v%0d empty", k),    32'(empty),    32'(vecs[k].exp_empty));
      checkOutput($sformatf("v%0d timeout", k),  32'(timeout),  32'(vecs[k].exp_timeout));
    end

    // Round-robin over ch0, ch1, ch3; a word pushed to ch2 in the cycle the
    // others run dry must not be granted until the following cycle.
    resetDut();
    applyStimulus(4'b1011, 32'hD000B0A0, 1'b0, 4'b0000);
    applyStimulus(4'b1011, 32'hD100B1A1, 1'b0, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b0000, 32'h0, 1'b1, 4'b0000);
      checkOutput($sformatf("rr%0d pop_ack", i), 32'(pop_ack), 32'h1);
      checkOutput($sformatf("rr%0d pop_ch", i),  32'(pop_ch),  32'(rr_ch[i]));
      if (i > 0) begin
        checkOutput($sformatf("rr%0d data_out", i), 32'(data_out), 32'(rr_dat[i-1]));
        checkOutput($sformatf("rr%0d data_ch", i),  32'(data_ch),  32'(rr_ch[i-1]));
      end
    end
    applyStimulus(4'b0100, 32'h00C00000, 1'b1, 4'b0000);
    checkOutput("rr dry pop_ack",  32'(pop_ack),  32'h0);
    checkOutput("rr dry push_ack", 32'(push_ack), 32'h4);
    checkOutput("rr dry data_out", 32'(data_out), 32'hD1);
    applyStimulus(4'b0000, 32'h0, 1'b1, 4'b0000);
    checkOutput("rr ch2 pop_ack", 32'(pop_ack), 32'h1);
    checkOutput("rr ch2 pop_ch",  32'(pop_ch),  32'h2);
    applyStimulus(4'b0000, 32'h0, 1'b0, 4'b0000);
    checkOutput("rr ch2 data_out", 32'(data_out), 32'hC0);
    checkOutput("rr ch2 data_ch",  32'(data_ch),  32'h2);

    // Push and pop together on a full ch2.
    resetDut();
    for (int i = 0; i < 16; i++)
      applyStimulus(4'b0100, {8'h00, 8'(8'h20 + i), 16'h0000}, 1'b0, 4'b0000);
    applyStimulus(4'b0100, 32'h00550000, 1'b1, 4'b0000);
    checkOutput("pp full",     32'(full),     32'h4);
    checkOutput("pp push_ack", 32'(push_ack), 32'h0);
    checkOutput("pp pop_ack",  32'(pop_ack),  32'h1);
    checkOutput("pp pop_ch",   32'(pop_ch),   32'h2);
    applyStimulus(4'b0100, 32'h00550000, 1'b0, 4'b0000);
    checkOutput("pp15 full",     32'(full),     32'h0);
    checkOutput("pp15 empty",    32'(empty),    32'hB);
    checkOutput("pp15 push_ack", 32'(push_ack), 32'h4);
    checkOutput("pp15 data_out", 32'(data_out), 32'h20);
    checkOutput("pp15 data_ch",  32'(data_ch),  32'h2);
    applyStimulus(4'b0000, 32'h0, 1'b0, 4'b0000);
    checkOutput("pp16 full", 32'(full), 32'h4);

    // Timeout on a full ch1: stall cycles 0..16, then one pop frees a slot.
    resetDut();
    for (int i = 0; i < 16; i++)
      applyStimulus(4'b0010, {16'h0000, 8'(8'h40 + i), 8'h00}, 1'b0, 4'b0000);
    for (int k = 0; k <= 16; k++) begin
      applyStimulus(4'b0010, 32'h00007700, 1'b0, 4'b0000);
      checkOutput($sformatf("tmo%0d timeout", k), 32'(timeout), (k >= 15) ? 32'h2 : 32'h0);
      checkOutput($sformatf("tmo%0d push_ack", k), 32'(push_ack), 32'h0);
    end
    applyStimulus(4'b0010, 32'h00007700, 1'b1, 4'b0000);
    checkOutput("tmo pop pop_ack", 32'(pop_ack), 32'h1);
    checkOutput("tmo pop pop_ch",  32'(pop_ch),  32'h1);
    checkOutput("tmo pop timeout", 32'(timeout), 32'h2);
    applyStimulus(4'b0010, 32'h00007700, 1'b0, 4'b0000);
    checkOutput("tmo free push_ack", 32'(push_ack), 32'h2);
    checkOutput("tmo free timeout",  32'(timeout),  32'h0);
    checkOutput("tmo free data_out", 32'(data_out), 32'h40);
    applyStimulus(4'b0000, 32'h0, 1'b0, 4'b0000);
    checkOutput("tmo end full", 32'(full), 32'h2);

    // Flush on ch3 with a colliding push; stored data is discarded.
    resetDut();
    for (int i = 0; i < 5; i++)
      applyStimulus(4'b1000, {8'(8'h30 + i), 24'h000000}, 1'b0, 4'b0000);
    applyStimulus(4'b0000, 32'h0, 1'b1, 4'b0000);
    checkOutput("fl pop_ch", 32'(pop_ch), 32'h3);
    applyStimulus(4'b1000, 32'h99000000, 1'b0, 4'b1000);
    checkOutput("fl push_ack", 32'(push_ack), 32'h0);
    checkOutput("fl empty",    32'(empty),    32'h7);
    checkOutput("fl data_out", 32'(data_out), 32'h30);
    applyStimulus(4'b1000, 32'h99000000, 1'b0, 4'b0000);
    checkOutput("fl+1 empty",    32'(empty),    32'hF);
    checkOutput("fl+1 push_ack", 32'(push_ack), 32'h8);
    checkOutput("fl+1 data_out", 32'(data_out), 32'h30);
    checkOutput("fl+1 data_ch",  32'(data_ch),  32'h3);
    applyStimulus(4'b0000, 32'h0, 1'b1, 4'b0000);
    checkOutput("fl+2 pop_ch", 32'(pop_ch), 32'h3);
    applyStimulus(4'b0000, 32'h0, 1'b0, 4'b0000);
    checkOutput("fl+3 data_out", 32'(data_out), 32'h99);
    checkOutput("fl+3 empty",    32'(empty),    32'hF);

    // Reset asserted in the middle of a pop handshake.
    resetDut();
    for (int i = 0; i < 3; i++)
      applyStimulus(4'b0001, 32'(8'hE0 + i), 1'b0, 4'b0000);
    applyStimulus(4'b0000, 32'h0, 1'b1, 4'b0000);
    applyStimulus(4'b0000, 32'h0, 1'b1, 4'b0000);
    checkOutput("rst mid pop_ack",  32'(pop_ack),  32'h1);
    checkOutput("rst mid data_out", 32'(data_out), 32'hE0);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("rst async pop_ack",  32'(pop_ack),  32'h0);
    checkOutput("rst async data_out", 32'(data_out), 32'h0);
    checkOutput("rst async empty",    32'(empty),    32'hF);
    checkOutput("rst async push_ack", 32'(push_ack), 32'h0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(4'b0000, 32'h0, 1'b1, 4'b0000);
    checkOutput("rst after pop_ack",  32'(pop_ack),  32'h0);
    checkOutput("rst after data_out", 32'(data_out), 32'h0);
    applyStimulus(4'b0001, 32'h0000005A, 1'b1, 4'b0000);
    checkOutput("rst push pop_ack",  32'(pop_ack),  32'h0);
    checkOutput("rst push push_ack", 32'(push_ack), 32'h1);
    applyStimulus(4'b0000, 32'h0, 1'b1, 4'b0000);
    checkOutput("rst pop pop_ack", 32'(pop_ack), 32'h1);
    checkOutput("rst pop pop_ch",  32'(pop_ch),  32'h0);
    applyStimulus(4'b0000, 32'h0, 1'b0, 4'b0000);
    checkOutput("rst pop data_out", 32'(data_out), 32'h5A);
    checkOutput("rst pop empty",    32'(empty),    32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
